// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_e        : loader FSM states
//   LEN_BYTES      : length-field bytes at the start of a frame
//   BYTES_PER_WORD : stream bytes packed into one instruction word
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_assembler.sv
// Packs accepted stream bytes little-endian into 32-bit words.
//   clk, res    : clock, synchronous active-high reset
//   clr         : restart packing at lane 0 (new load)
//   byte_valid  : a data byte is consumed this cycle
//   byte_data   : the consumed byte
//   lane_last   : the next consumed byte completes a word
//   word_ready  : one-cycle pulse, word_data holds a freshly completed word
//   word_data   : last completed word (held between pulses)
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        res,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        lane_last,
  output logic        word_ready,
  output logic [31:0] word_data
);

  logic [1:0]       lane_idx_q, lane_idx_d;
  logic [2:0][7:0]  lane_q, lane_d;
  logic             word_ready_q, word_ready_d;
  logic [31:0]      word_q, word_d;

  assign lane_last = (lane_idx_q == 2'(BYTES_PER_WORD - 1));

  // Only the lower three lanes need storage; the top byte goes straight into
  // the output word so the next word's byte 0 can land without disturbing it.
  for (genvar gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
    assign lane_d[gi] = (byte_valid && lane_idx_q == 2'(gi)) ? byte_data : lane_q[gi];
  end

  always_comb begin
    lane_idx_d   = lane_idx_q;
    word_ready_d = 1'b0;
    word_d       = word_q;
    if (clr) begin
      lane_idx_d = 2'd0;
    end else if (byte_valid) begin
      lane_idx_d = lane_idx_q + 2'd1;
      if (lane_last) begin
        word_ready_d = 1'b1;
        word_d       = {byte_data, lane_q[2], lane_q[1], lane_q[0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      lane_idx_q   <= '0;
      lane_q       <= '0;
      word_ready_q <= 1'b0;
      word_q       <= '0;
    end else begin
      lane_idx_q   <= lane_idx_d;
      lane_q       <= lane_d;
      word_ready_q <= word_ready_d;
      word_q       <= word_d;
    end
  end

  assign word_ready = word_ready_q;
  assign word_data  = word_q;

endmodule

// File: rtl/imem_loader.sv
// Writer side of the CPU instruction memory. Receives a framed program image
// as a byte stream and writes it word-addressed into instruction memory,
// holding the CPU in reset while loading.
//   clk, res     : clock, synchronous active-high reset
//   start        : one-cycle pulse that begins a load (from IDLE/DONE/ERR)
//   rx_valid/rx_data/rx_ready : byte stream handshake
//   imem_we/imem_addr/imem_wdata : instruction memory write port
//   word_count   : words written in the current load
//   cpu_hold     : hold the CPU in reset
//   done / err   : load finished with good checksum / load aborted
// Frame: LEN_LO, LEN_HI, 4*N data bytes, CSUM (XOR of data bytes).
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] MAX_WORDS_W = 17'(MAX_WORDS);

  state_e              state_q, state_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [15:0]         len_q, len_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [7:0]          xor_q, xor_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept;
  logic                start_ok;
  logic                data_accept;
  logic                lane_last;
  logic                word_done;
  logic [15:0]         len_full;

  assign rx_ready    = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                       (state_q == S_DATA)   || (state_q == S_CSUM);
  assign accept      = rx_valid && rx_ready;
  assign start_ok    = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                 (state_q == S_ERR));
  assign data_accept = accept && (state_q == S_DATA);
  assign word_done   = data_accept && lane_last;
  assign len_full    = {rx_data, len_lo_q};

  word_assembler u_asm (
    .clk        (clk),
    .res        (res),
    .clr        (start_ok),
    .byte_valid (data_accept),
    .byte_data  (rx_data),
    .lane_last  (lane_last),
    .word_ready (imem_we),
    .word_data  (imem_wdata)
  );

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    word_count_d = word_count_q;
    imem_addr_d  = imem_addr_q;
    xor_d        = xor_q;
    cpu_hold_d   = cpu_hold_q;
    done_d       = done_q;
    err_d        = err_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_ok) begin
          state_d      = S_LEN_LO;
          cpu_hold_d   = 1'b1;
          done_d       = 1'b0;
          err_d        = 1'b0;
          word_count_d = '0;
          xor_d        = '0;
          len_d        = '0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_lo_d = rx_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d = len_full;
          if ({1'b0, len_full} > MAX_WORDS_W) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (len_full == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_d = xor_q ^ rx_data;
          if (word_done) begin
            // Count moves together with the write strobe, which the
            // assembler raises on the cycle after this byte.
            imem_addr_d  = word_count_q[ADDR_W-1:0];
            word_count_d = word_count_q + 1'b1;
            if (17'(word_count_q) + 17'd1 == {1'b0, len_q}) begin
              state_d = S_CSUM;
            end
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (rx_data == xor_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= S_IDLE;
      len_lo_q     <= '0;
      len_q        <= '0;
      word_count_q <= '0;
      imem_addr_q  <= '0;
      xor_q        <= '0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      word_count_q <= word_count_d;
      imem_addr_q  <= imem_addr_d;
      xor_q        <= xor_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign imem_addr  = imem_addr_q;
  assign word_count = word_count_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are sent byte by byte, memory
// writes are logged at the falling edge and compared with hand-computed words.
module tb_imem_loader;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              res;
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              cpu_hold;
  logic              done;
  logic              err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  frame[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic [31:0] wr_cnt_log[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .res        (res),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .word_count (word_count),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_log.push_back(32'(imem_addr));
      wr_data_log.push_back(imem_wdata);
      wr_cnt_log.push_back(32'(word_count));
      $display("write addr=%0d data=%08h word_count=%0d", imem_addr, imem_wdata, word_count);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  task automatic clear_log();
    wr_addr_log.delete();
    wr_data_log.delete();
    wr_cnt_log.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte and wait (bounded) until the loader takes it.
  task automatic send_byte(input logic [7:0] b);
    bit taken = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 20 && !taken; i++) begin
      @(negedge clk);
      if (rx_ready) taken = 1;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!taken) check_eq("byte_timeout", 32'(b), 32'hFFFF_FFFF);
  endtask

  task automatic send_frame(input int max_gap);
    foreach (frame[i]) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk); #1;
      end
      send_byte(frame[i]);
    end
    // Let a trailing write strobe (if any) reach the log.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  task automatic check_prog(input string tag);
    check_eq({tag, "_nwr"}, 32'(wr_addr_log.size()), 32'd2);
    if (wr_addr_log.size() == 2) begin
      check_eq({tag, "_a0"}, wr_addr_log[0], 32'd0);
      check_eq({tag, "_d0"}, wr_data_log[0], 32'h0010_0513);
      check_eq({tag, "_c0"}, wr_cnt_log[0], 32'd1);
      check_eq({tag, "_a1"}, wr_addr_log[1], 32'd1);
      check_eq({tag, "_d1"}, wr_data_log[1], 32'hF005_1073);
      check_eq({tag, "_c1"}, wr_cnt_log[1], 32'd2);
    end
  endtask

  initial begin
    res = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(rx_ready), 32'd0);
    check_eq("rst_we",    32'(imem_we),  32'd0);
    check_eq("rst_hold",  32'(cpu_hold), 32'd0);
    check_eq("rst_done",  32'(done),     32'd0);
    check_eq("rst_err",   32'(err),      32'd0);
    check_eq("rst_wc",    32'(word_count), 32'd0);
    @(posedge clk); #1;
    res = 1'b0;

    // Good two-word image.
    clear_log();
    pulse_start();
    @(negedge clk);
    check_eq("t2_hold_load", 32'(cpu_hold), 32'd1);
    @(posedge clk); #1;
    frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h73, 8'h10, 8'h05, 8'hF0, 8'h90};
    send_frame(0);
    check_prog("t2");
    check_eq("t2_wc",    32'(word_count), 32'd2);
    check_eq("t2_done",  32'(done),       32'd1);
    check_eq("t2_err",   32'(err),        32'd0);
    check_eq("t2_hold",  32'(cpu_hold),   32'd0);
    check_eq("t2_addr_hold",  32'(imem_addr), 32'd1);
    check_eq("t2_wdata_hold", imem_wdata,     32'hF005_1073);
    check_eq("t2_ready", 32'(rx_ready),   32'd0);
    @(posedge clk); #1;

    // Same image, bad checksum.
    clear_log();
    pulse_start();
    frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h73, 8'h10, 8'h05, 8'hF0, 8'h91};
    send_frame(0);
    check_prog("t3");
    check_eq("t3_err",  32'(err),      32'd1);
    check_eq("t3_hold", 32'(cpu_hold), 32'd1);
    check_eq("t3_done", 32'(done),     32'd0);
    @(posedge clk); #1;

    // Empty image.
    clear_log();
    pulse_start();
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(0);
    check_eq("t4_nwr",  32'(wr_addr_log.size()), 32'd0);
    check_eq("t4_done", 32'(done),     32'd1);
    check_eq("t4_hold", 32'(cpu_hold), 32'd0);
    check_eq("t4_wc",   32'(word_count), 32'd0);
    @(posedge clk); #1;

    // Oversize length 0x1001.
    clear_log();
    pulse_start();
    frame = '{8'h01, 8'h10};
    send_frame(0);
    check_eq("t5_err",   32'(err),      32'd1);
    check_eq("t5_ready", 32'(rx_ready), 32'd0);
    check_eq("t5_nwr",   32'(wr_addr_log.size()), 32'd0);
    check_eq("t5_hold",  32'(cpu_hold), 32'd1);
    @(posedge clk); #1;

    // Good image with random stream gaps.
    clear_log();
    pulse_start();
    frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h73, 8'h10, 8'h05, 8'hF0, 8'h90};
    send_frame(3);
    check_prog("t6");
    check_eq("t6_done", 32'(done), 32'd1);
    @(posedge clk); #1;

    // Reset after five data bytes.
    clear_log();
    pulse_start();
    frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h73};
    foreach (frame[i]) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send_byte(frame[i]);
    end
    res = 1'b1;
    @(posedge clk); #1;
    res = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("t6r_nwr", 32'(wr_addr_log.size()), 32'd1);
    if (wr_addr_log.size() >= 1) begin
      check_eq("t6r_a0", wr_addr_log[0], 32'd0);
      check_eq("t6r_d0", wr_data_log[0], 32'h0010_0513);
    end
    check_eq("t6r_hold",  32'(cpu_hold),   32'd0);
    check_eq("t6r_ready", 32'(rx_ready),   32'd0);
    check_eq("t6r_wc",    32'(word_count), 32'd0);
    check_eq("t6r_done",  32'(done),       32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
